// File: rtl/rf_cmd_pkg.sv
// rtl/rf_cmd_pkg.sv - shared command codes, FSM states and default timing for the RF command scheduler
package rf_cmd_pkg;

  localparam logic [1:0] CMD_CFG = 2'd0;
  localparam logic [1:0] CMD_ASK = 2'd1;
  localparam logic [1:0] CMD_CPI = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ANS = 2'd2
  } state_t;

  localparam int TIMEOUT_CYC_DEF  = 200000;
  localparam int MAX_RETRY_DEF    = 3;
  localparam int BLACKOUT_CYC_DEF = 4000;

endpackage

// File: rtl/rf_edge_sync.sv
// rtl/rf_edge_sync.sv - 2-flop synchroniser followed by a one-cycle rising-edge pulse
module rf_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  // sr[1:0] is the synchroniser, sr[2] the previous synchronised value
  logic [2:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[1:0], level};
    end
  end

  assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/rf_cmd_sched.sv
// rtl/rf_cmd_sched.sv - RF command scheduler: arbitration, issue/answer tracking, retry and CPI blackout
module rf_cmd_sched
  import rf_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  parameter int MAX_RETRY    = MAX_RETRY_DEF,
  parameter int BLACKOUT_CYC = BLACKOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_init,
  input  logic [31:0] i_stop,
  input  logic        i_pre_cpi,
  input  logic        i_cpi,
  input  logic [31:0] i_rf_data,
  input  logic [31:0] i_up_gain,
  input  logic [31:0] i_down_gain,
  input  logic        i_rf_data_vld,
  input  logic        i_rf_ask_flag,
  output logic        o_cmd_vld,
  input  logic        i_cmd_rdy,
  output logic [1:0]  o_cmd_type,
  output logic [31:0] o_cmd_freq,
  output logic [31:0] o_cmd_up_gain,
  output logic [31:0] o_cmd_down_gain,
  input  logic        i_ans_vld,
  input  logic        i_ans_ok,
  output logic        o_busy,
  output logic [31:0] o_send_num,
  output logic [31:0] o_ans_num,
  output logic [15:0] o_fail_num,
  output logic        o_err
);

  logic pre_cpi_rise, cpi_rise, cfg_rise, ask_rise, init_rise;

  rf_edge_sync u_sync_pre_cpi (.clk(clk), .rst(rst), .level(i_pre_cpi),     .rise(pre_cpi_rise));
  rf_edge_sync u_sync_cpi     (.clk(clk), .rst(rst), .level(i_cpi),         .rise(cpi_rise));
  rf_edge_sync u_sync_cfg     (.clk(clk), .rst(rst), .level(i_rf_data_vld), .rise(cfg_rise));
  rf_edge_sync u_sync_ask     (.clk(clk), .rst(rst), .level(i_rf_ask_flag), .rise(ask_rise));
  rf_edge_sync u_sync_init    (.clk(clk), .rst(rst), .level(i_init[0]),     .rise(init_rise));

  logic [31:0] sh_freq, sh_up, sh_down;
  logic        pend_cpi, pend_cfg, pend_ask;
  state_t      state, state_nxt;
  logic [31:0] to_cnt, blk_cnt;
  logic [7:0]  retry_cnt;
  logic        grant_cpi, grant_cfg, grant_ask;
  logic        accept, ans_good, retry, drop;
  logic        can_grant;
  logic        unused_bits;

  assign unused_bits = ^{i_init[31:1], i_stop[31:1]};

  // a cpi edge seen this cycle already counts as blackout
  assign can_grant = !i_stop[0] && (blk_cnt == '0) && !cpi_rise;
  assign o_cmd_vld = (state == ISSUE);
  assign o_busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_cpi = 1'b0;
    grant_cfg = 1'b0;
    grant_ask = 1'b0;
    accept    = 1'b0;
    ans_good  = 1'b0;
    retry     = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (can_grant) begin
          if (pend_cpi) begin
            grant_cpi = 1'b1;
            state_nxt = ISSUE;
          end else if (pend_cfg) begin
            grant_cfg = 1'b1;
            state_nxt = ISSUE;
          end else if (pend_ask) begin
            grant_ask = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (i_cmd_rdy) begin
          accept    = 1'b1;
          state_nxt = WAIT_ANS;
        end
      end
      WAIT_ANS: begin
        if (i_ans_vld && i_ans_ok) begin
          ans_good  = 1'b1;
          state_nxt = IDLE;
        end else if (i_ans_vld || (to_cnt == '0)) begin
          if (retry_cnt < 8'(MAX_RETRY)) begin
            retry     = 1'b1;
            state_nxt = ISSUE;
          end else begin
            drop      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (init_rise) begin
      state_nxt = IDLE;
    end
  end

  // shadow registers survive a soft clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_freq <= '0;
      sh_up   <= '0;
      sh_down <= '0;
    end else if (cfg_rise) begin
      sh_freq <= i_rf_data;
      sh_up   <= i_up_gain;
      sh_down <= i_down_gain;
    end
  end

  // a new edge on the grant cycle stays pending rather than being lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cpi <= 1'b0;
      pend_cfg <= 1'b0;
      pend_ask <= 1'b0;
    end else if (init_rise) begin
      pend_cpi <= 1'b0;
      pend_cfg <= 1'b0;
      pend_ask <= 1'b0;
    end else begin
      if (grant_cpi) begin
        pend_cpi <= 1'b0;
        pend_cfg <= 1'b0;
      end
      if (grant_cfg) pend_cfg <= 1'b0;
      if (grant_ask) pend_ask <= 1'b0;
      if (pre_cpi_rise) pend_cpi <= 1'b1;
      if (cfg_rise)     pend_cfg <= 1'b1;
      if (ask_rise)     pend_ask <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_cmd_type      <= CMD_CFG;
      o_cmd_freq      <= '0;
      o_cmd_up_gain   <= '0;
      o_cmd_down_gain <= '0;
    end else if (grant_ask && !init_rise) begin
      o_cmd_type      <= CMD_ASK;
      o_cmd_freq      <= '0;
      o_cmd_up_gain   <= '0;
      o_cmd_down_gain <= '0;
    end else if ((grant_cpi || grant_cfg) && !init_rise) begin
      o_cmd_type      <= grant_cpi ? CMD_CPI : CMD_CFG;
      o_cmd_freq      <= sh_freq;
      o_cmd_up_gain   <= sh_up;
      o_cmd_down_gain <= sh_down;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_send_num <= '0;
      o_ans_num  <= '0;
      o_fail_num <= '0;
      o_err      <= 1'b0;
      retry_cnt  <= '0;
      to_cnt     <= '0;
    end else if (init_rise) begin
      o_send_num <= '0;
      o_ans_num  <= '0;
      o_fail_num <= '0;
      o_err      <= 1'b0;
      retry_cnt  <= '0;
      to_cnt     <= '0;
    end else begin
      o_err <= drop;
      if (accept) o_send_num <= o_send_num + 32'd1;
      if (ans_good) o_ans_num <= o_ans_num + 32'd1;
      if (drop && (o_fail_num != 16'hFFFF)) o_fail_num <= o_fail_num + 16'd1;
      if (retry) begin
        retry_cnt <= retry_cnt + 8'd1;
      end else if (ans_good || drop) begin
        retry_cnt <= '0;
      end
      if (accept) begin
        to_cnt <= 32'(TIMEOUT_CYC);
      end else if ((state == WAIT_ANS) && (to_cnt != '0)) begin
        to_cnt <= to_cnt - 32'd1;
      end
    end
  end

  // blackout keeps running through a soft clear so no issue can slip inside the window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt <= '0;
    end else if (cpi_rise) begin
      blk_cnt <= 32'(BLACKOUT_CYC);
    end else if (blk_cnt != '0) begin
      blk_cnt <= blk_cnt - 32'd1;
    end
  end

endmodule

// File: tb/tb_rf_cmd_sched.sv
// tb/tb_rf_cmd_sched.sv - self-checking bench for rf_cmd_sched with a command-level reference model
module tb_rf_cmd_sched;

  localparam int TO  = 50;
  localparam int BLK = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_init, i_stop;
  logic        i_pre_cpi, i_cpi, i_rf_data_vld, i_rf_ask_flag;
  logic [31:0] i_rf_data, i_up_gain, i_down_gain;
  logic        o_cmd_vld, i_cmd_rdy;
  logic [1:0]  o_cmd_type;
  logic [31:0] o_cmd_freq, o_cmd_up_gain, o_cmd_down_gain;
  logic        i_ans_vld, i_ans_ok, o_busy, o_err;
  logic [31:0] o_send_num, o_ans_num;
  logic [15:0] o_fail_num;

  rf_cmd_sched #(.TIMEOUT_CYC(TO), .MAX_RETRY(3), .BLACKOUT_CYC(BLK)) dut (
    .clk(clk), .rst(rst), .i_init(i_init), .i_stop(i_stop),
    .i_pre_cpi(i_pre_cpi), .i_cpi(i_cpi),
    .i_rf_data(i_rf_data), .i_up_gain(i_up_gain), .i_down_gain(i_down_gain),
    .i_rf_data_vld(i_rf_data_vld), .i_rf_ask_flag(i_rf_ask_flag),
    .o_cmd_vld(o_cmd_vld), .i_cmd_rdy(i_cmd_rdy), .o_cmd_type(o_cmd_type),
    .o_cmd_freq(o_cmd_freq), .o_cmd_up_gain(o_cmd_up_gain), .o_cmd_down_gain(o_cmd_down_gain),
    .i_ans_vld(i_ans_vld), .i_ans_ok(i_ans_ok), .o_busy(o_busy),
    .o_send_num(o_send_num), .o_ans_num(o_ans_num), .o_fail_num(o_fail_num), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  t;
    logic [31:0] f, u, d;
    int          cyc;
  } rec_t;

  rec_t mon_q[$];
  int   cyc = 0;
  int   err_cnt = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   exp_send = 0, exp_ans = 0, exp_fail = 0;
  int   base, t0, err0;
  logic [31:0] f, u, d;

  always @(posedge clk) cyc <= cyc + 1;

  // every accepted handshake is logged as one issued command
  always @(negedge clk) begin
    if (!rst && o_cmd_vld && i_cmd_rdy)
      mon_q.push_back('{t: o_cmd_type, f: o_cmd_freq, u: o_cmd_up_gain, d: o_cmd_down_gain, cyc: cyc});
    if (!rst && o_err) err_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // m = {init, cpi, pre_cpi, ask, cfg}
  task automatic rise(input logic [4:0] m);
    if (m[0]) i_rf_data_vld = 1'b1;
    if (m[1]) i_rf_ask_flag = 1'b1;
    if (m[2]) i_pre_cpi = 1'b1;
    if (m[3]) i_cpi = 1'b1;
    if (m[4]) i_init = $urandom() | 32'h1;
    step(3);
    i_rf_data_vld = 1'b0;
    i_rf_ask_flag = 1'b0;
    i_pre_cpi     = 1'b0;
    i_cpi         = 1'b0;
    i_init        = $urandom() & ~32'h1;
    step(1);
  endtask

  task automatic answer(input logic ok);
    i_ans_vld = 1'b1;
    i_ans_ok  = ok;
    step(1);
    i_ans_vld = 1'b0;
    i_ans_ok  = $urandom_range(0, 1);
  endtask

  task automatic wait_cmd(input string tag, input int n);
    for (int k = 0; k < 400 && mon_q.size() < n; k++) step(1);
    chk(tag, mon_q.size(), n);
  endtask

  task automatic chk_cmd(input string tag, input int idx, input logic [1:0] t,
                         input logic [31:0] ef, input logic [31:0] eu, input logic [31:0] ed);
    if (idx < mon_q.size()) begin
      chk({tag, "_type"}, mon_q[idx].t, t);
      chk({tag, "_freq"}, mon_q[idx].f, ef);
      chk({tag, "_up"},   mon_q[idx].u, eu);
      chk({tag, "_down"}, mon_q[idx].d, ed);
    end else begin
      chk({tag, "_present"}, mon_q.size(), idx + 1);
    end
  endtask

  task automatic new_payload();
    f = $urandom(); u = $urandom(); d = $urandom();
    i_rf_data = f; i_up_gain = u; i_down_gain = d;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_send"}, o_send_num, exp_send);
    chk({tag, "_ans"},  o_ans_num,  exp_ans);
    chk({tag, "_fail"}, o_fail_num, exp_fail);
    chk({tag, "_busy"}, o_busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    i_init = 32'h0; i_stop = $urandom() & ~32'h1;
    i_pre_cpi = 0; i_cpi = 0; i_rf_data_vld = 0; i_rf_ask_flag = 0;
    i_rf_data = 0; i_up_gain = 0; i_down_gain = 0;
    i_cmd_rdy = 1'b1; i_ans_vld = 0; i_ans_ok = 0;
    step(3);
    chk("rst_vld", o_cmd_vld, 1'b0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_type", o_cmd_type, 2'd0);
    chk_counts("rst");
    rst = 1'b0;
    step(2);

    // CFG success with fixed payload
    f = 32'h0000_1F40; u = 32'h10; d = 32'h20;
    i_rf_data = f; i_up_gain = u; i_down_gain = d;
    rise(5'b00001);
    wait_cmd("cfg_issue", 1);
    exp_send++;
    chk_cmd("cfg", 0, 2'd0, f, u, d);
    step($urandom_range(5, 40));
    answer(1'b1);
    exp_ans++;
    step(2);
    chk_counts("cfg_done");

    // simultaneous requests: CPI apply absorbs the config, ask follows
    new_payload();
    base = mon_q.size();
    rise(5'b00111);
    wait_cmd("sim_first", base + 1);
    exp_send++;
    chk_cmd("sim_cpi", base, 2'd2, f, u, d);
    step(3); answer(1'b1); exp_ans++;
    wait_cmd("sim_second", base + 2);
    exp_send++;
    chk_cmd("sim_ask", base + 1, 2'd1, 32'h0, 32'h0, 32'h0);
    step(3); answer(1'b1); exp_ans++;
    step(30);
    chk("sim_no_extra", mon_q.size(), base + 2);
    chk_counts("sim_done");

    // timeout with all retries exhausted
    new_payload();
    base = mon_q.size();
    err0 = err_cnt;
    rise(5'b00001);
    wait_cmd("to_issues", base + 4);
    exp_send += 4;
    exp_fail++;
    for (int i = 0; i < 4; i++) chk_cmd("to_retry", base + i, 2'd0, f, u, d);
    for (int i = 1; i < 4; i++)
      chk("to_gap", (mon_q[base + i].cyc - mon_q[base + i - 1].cyc) >= TO, 1'b1);
    step(TO + 10);
    chk("to_err_pulses", err_cnt - err0, 1);
    chk("to_no_extra", mon_q.size(), base + 4);
    chk_counts("to_done");

    // bad answer retried, good answer completes
    base = mon_q.size();
    err0 = err_cnt;
    rise(5'b00010);
    wait_cmd("bad_first", base + 1);
    step(2); answer(1'b0);
    wait_cmd("bad_retry", base + 2);
    exp_send += 2;
    chk_cmd("bad_ask", base + 1, 2'd1, 32'h0, 32'h0, 32'h0);
    step(2); answer(1'b1); exp_ans++;
    step(3);
    chk("bad_no_err", err_cnt - err0, 0);
    chk_counts("bad_done");

    // blackout holds off a config requested 10 cycles after the cpi edge
    base = mon_q.size();
    t0 = cyc;
    rise(5'b01000);
    step(6);
    new_payload();
    rise(5'b00001);
    wait_cmd("blk_issue", base + 1);
    exp_send++;
    chk("blk_gap", (mon_q[base].cyc - t0) >= BLK, 1'b1);
    chk_cmd("blk", base, 2'd0, f, u, d);
    step(2); answer(1'b1); exp_ans++;

    // stop blocks the grant but keeps the request
    i_stop = $urandom() | 32'h1;
    new_payload();
    rise(5'b00001);
    step(30);
    chk("stop_hold", mon_q.size(), base + 1);
    chk("stop_idle", o_busy, 1'b0);
    i_stop = $urandom() & ~32'h1;
    wait_cmd("stop_release", base + 2);
    exp_send++;
    chk_cmd("stop", base + 1, 2'd0, f, u, d);
    step(2); answer(1'b1); exp_ans++;
    step(2);
    chk_counts("stop_done");

    // soft clear while waiting for an answer, with a config pending
    base = mon_q.size();
    rise(5'b00010);
    wait_cmd("init_issue", base + 1);
    step(2);
    rise(5'b00001);
    chk("init_busy_before", o_busy, 1'b1);
    rise(5'b10000);
    exp_send = 0; exp_ans = 0; exp_fail = 0;
    chk_counts("init");
    step(40);
    chk("init_pend_cleared", mon_q.size(), base + 1);
    answer(1'b1);
    step(2);
    chk("init_ans_ignored", o_ans_num, 32'h0);

    // asynchronous reset while a command is being offered
    i_cmd_rdy = 1'b0;
    rise(5'b00010);
    for (int k = 0; k < 20 && !o_cmd_vld; k++) step(1);
    chk("rst_issue_vld", o_cmd_vld, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_vld", o_cmd_vld, 1'b0);
    chk("rst_async_busy", o_busy, 1'b0);
    step(2);
    rst = 1'b0;
    i_cmd_rdy = 1'b1;
    step(20);
    chk("rst_no_issue", mon_q.size(), base + 1);
    chk_counts("rst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
